// File: rtl/mac_col_if.sv
// Column bus: query/instruction in from the previous column, forwarded
// copies out to the next column, plus the chunk result and status.
interface mac_col_if #(
  parameter int unsigned BW     = 8,
  parameter int unsigned PR     = 8,
  parameter int unsigned BW_ACC = 2*BW+8
) ();
  logic [PR*BW-1:0]  q_in;
  logic [2:0]        i_inst;
  logic [PR*BW-1:0]  q_out;
  logic [2:0]        o_inst;
  logic [BW_ACC-1:0] out;
  logic              fifo_wr;
  logic              err;

  // Upstream side: drives query/instruction, receives forwarded data and results.
  modport master (
    output q_in, i_inst,
    input  q_out, o_inst, out, fifo_wr, err
  );

  // Column side.
  modport slave (
    input  q_in, i_inst,
    output q_out, o_inst, out, fifo_wr, err
  );
endinterface

// File: rtl/mac_col_acc.sv
// Systolic MAC column: stationary double-buffered key, PR-lane signed dot
// product per execute beat, multi-beat chunk accumulation, one result
// strobe per chunk. Query and instruction are forwarded with one cycle skew.
module mac_col_acc #(
  parameter int unsigned BW      = 8,
  parameter int unsigned PR      = 8,
  parameter int unsigned BW_PSUM = 2*BW+4,
  parameter int unsigned BW_ACC  = 2*BW+8,
  parameter int unsigned NUM_COL = 8,
  parameter int unsigned COL_ID  = 0
) (
  input logic        clk,
  input logic        reset,
  mac_col_if.slave   bus
);

  localparam int unsigned VW    = PR * BW;
  localparam int unsigned CNT_W = $clog2(NUM_COL) + 1;
  // Beat of a load burst that belongs to this column.
  localparam logic [CNT_W-1:0] CAP_IDX = CNT_W'(NUM_COL - 1 - COL_ID);

  typedef enum logic {
    ACC_IDLE,
    ACC_RUN
  } acc_state_e;

  acc_state_e state_q, state_d;

  // Forwarding stage
  logic [2:0]    inst_q;
  logic [VW-1:0] query_q;

  // Key buffers and load tracking
  logic [VW-1:0]    key_shadow;
  logic [VW-1:0]    key_active;
  logic             key_pending;
  logic [CNT_W-1:0] cnt;
  logic             cap_done;

  // Instruction decode
  logic load_c, exec_c, last_c, conflict_c;
  logic first_c, promote_c;

  // Pipeline qualifiers: valid, last, first-of-chunk
  logic v1, l1, f1;
  logic v2, l2, f2;

  // Datapath
  logic signed [BW_PSUM-1:0] psum_c;
  logic signed [BW_PSUM-1:0] psum_q;
  logic signed [BW_ACC-1:0]  acc;
  logic signed [BW_ACC-1:0]  acc_c;
  logic [BW_ACC-1:0]         out_q;
  logic                      fifo_wr_q;
  logic                      err_q;

  // Load has priority; execute/last only count when load is absent.
  always_comb begin
    load_c     = bus.i_inst[0];
    exec_c     = bus.i_inst[1] & ~bus.i_inst[0];
    last_c     = exec_c & bus.i_inst[2];
    conflict_c = (bus.i_inst[0] & bus.i_inst[1]) | (bus.i_inst[2] & ~bus.i_inst[1]);
  end

  // Chunk state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Chunk next state; a beat seen while idle opens a chunk and may promote the key.
  always_comb begin
    state_d   = state_q;
    first_c   = 1'b0;
    promote_c = 1'b0;
    if (exec_c) begin
      first_c   = (state_q == ACC_IDLE);
      promote_c = first_c & key_pending;
      state_d   = last_c ? ACC_IDLE : ACC_RUN;
    end
  end

  // Forwarding registers toward the next column.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q  <= '0;
      query_q <= '0;
    end else begin
      inst_q <= bus.i_inst;
      if (bus.i_inst[0] | bus.i_inst[1]) begin
        query_q <= bus.q_in;
      end
    end
  end

  // Load burst counter: one capture per burst at this column's beat index.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      cap_done   <= 1'b0;
      key_shadow <= '0;
    end else if (load_c) begin
      if (!cap_done) begin
        if (cnt == CAP_IDX) begin
          key_shadow <= bus.q_in;
          cap_done   <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end else if (inst_q[0]) begin
      cnt      <= '0;
      cap_done <= 1'b0;
    end
  end

  // Key double buffer: shadow is promoted only when a new chunk starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_pending <= 1'b0;
      key_active  <= '0;
    end else if (load_c && !cap_done && cnt == CAP_IDX) begin
      key_pending <= 1'b1;
    end else if (promote_c) begin
      key_active  <= key_shadow;
      key_pending <= 1'b0;
    end
  end

  // PR-lane signed dot product, operands sign-extended before multiplying.
  always_comb begin
    psum_c = '0;
    for (int unsigned i = 0; i < PR; i++) begin
      psum_c = psum_c
             + BW_PSUM'($signed(query_q[i*BW +: BW]))
             * BW_PSUM'($signed(key_active[i*BW +: BW]));
    end
  end

  // Accumulator input: restart from zero on the first beat of a chunk.
  always_comb begin
    acc_c = (f2 ? '0 : acc) + BW_ACC'(psum_q);
  end

  // Beat qualifiers travel alongside the datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      f1 <= 1'b0;
      v2 <= 1'b0;
      l2 <= 1'b0;
      f2 <= 1'b0;
    end else begin
      v1 <= exec_c;
      l1 <= last_c;
      f1 <= first_c;
      v2 <= v1;
      l2 <= l1;
      f2 <= f1;
    end
  end

  // Per-beat partial sum register.
  always_ff @(posedge clk) begin
    if (reset) begin
      psum_q <= '0;
    end else if (v1) begin
      psum_q <= psum_c;
    end
  end

  // Accumulate and present the result with a one-cycle write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      out_q     <= '0;
      fifo_wr_q <= 1'b0;
    end else begin
      fifo_wr_q <= v2 & l2;
      if (v2) begin
        acc <= acc_c;
      end
      if (v2 & l2) begin
        out_q <= acc_c;
      end
    end
  end

  // Sticky protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (conflict_c) begin
      err_q <= 1'b1;
    end
  end

  assign bus.q_out   = query_q;
  assign bus.o_inst  = inst_q;
  assign bus.out     = out_q;
  assign bus.fifo_wr = fifo_wr_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mac_col_acc.sv
// Scoreboard bench for mac_col_acc (COL_ID=2 of 8 columns).
module tb_mac_col_acc;

  localparam int unsigned BW     = 8;
  localparam int unsigned PR     = 8;
  localparam int unsigned BW_ACC = 2*BW+8;
  localparam int unsigned VW     = PR*BW;

  typedef struct {
    logic [BW_ACC-1:0] val;
    int unsigned       due;
  } exp_t;

  logic clk;
  logic reset;
  int unsigned cyc;
  int vectors;
  int miscompares;
  exp_t sb_q[$];
  logic [VW-1:0] exp_q;
  logic [2:0]    exp_inst;

  mac_col_if #(.BW(BW), .PR(PR), .BW_ACC(BW_ACC)) bus ();

  mac_col_acc #(
    .BW(BW), .PR(PR), .BW_PSUM(2*BW+4), .BW_ACC(BW_ACC),
    .NUM_COL(8), .COL_ID(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] fill(input logic [BW-1:0] v);
    return {PR{v}};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int val);
    exp_t e;
    e.val = BW_ACC'(val);
    e.due = cyc + 3;
    sb_q.push_back(e);
  endtask

  // One input beat; first checks the forwarded copy of the previous beat.
  task automatic step(input logic [2:0] inst, input logic [VW-1:0] q);
    @(negedge clk);
    check("q_out", bus.q_out, exp_q);
    check("o_inst", VW'(bus.o_inst), VW'(exp_inst));
    bus.i_inst = inst;
    bus.q_in   = q;
    if (inst[0] | inst[1]) exp_q = q;
    exp_inst = inst;
  endtask

  // 8-beat load burst; this column keeps beat 5.
  task automatic load_key(input logic [BW-1:0] k, input logic [2:0] key_inst);
    for (int b = 0; b < 8; b++) begin
      if (b == 5) step(key_inst, fill(k));
      else        step(3'b001, fill(8'h55));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      bus.q_in   = {$urandom, $urandom};
      bus.i_inst = 3'($urandom);
      @(negedge clk);
    end
    check("rst_out", VW'(bus.out), '0);
    check("rst_fifo_wr", VW'(bus.fifo_wr), '0);
    check("rst_err", VW'(bus.err), '0);
    check("rst_q_out", bus.q_out, '0);
    check("rst_o_inst", VW'(bus.o_inst), '0);
    reset      = 1'b0;
    bus.q_in   = '0;
    bus.i_inst = '0;
    exp_q      = '0;
    exp_inst   = '0;
  endtask

  // Monitor: every strobe must match the oldest expected result and its cycle.
  always @(negedge clk) begin
    if (bus.fifo_wr === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_fifo_wr: out=%0h at cycle %0d", bus.out, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (bus.out !== e.val) begin
          miscompares++;
          $display("FAIL result: got %0h expected %0h at cycle %0d", bus.out, e.val, cyc);
        end
        vectors++;
        if (cyc != e.due) begin
          miscompares++;
          $display("FAIL latency: strobe at cycle %0d expected %0d", cyc, e.due);
        end
      end
    end
  end

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.q_in    = '0;
    bus.i_inst  = '0;
    exp_q       = '0;
    exp_inst    = '0;

    do_reset();
    step(3'b000, '0);

    // Key capture: beat k carries lanes all k; column 2 keeps k=5.
    for (int k = 0; k < 8; k++) step(3'b001, fill(BW'(k)));
    step(3'b110, fill(8'd1));
    push(40);
    step(3'b000, '0);

    // Accumulation with an idle cycle inside the chunk.
    load_key(8'd3, 3'b001);
    step(3'b010, fill(8'd1));
    step(3'b010, fill(8'd2));
    step(3'b000, '0);
    step(3'b010, fill(8'd3));
    step(3'b110, fill(8'd4));
    push(240);
    step(3'b000, '0);

    // Double buffering: key B loaded mid-chunk, then back-to-back chunk.
    load_key(8'd1, 3'b001);
    step(3'b010, fill(8'd2));
    step(3'b010, fill(8'd2));
    load_key(8'hFF, 3'b001);
    step(3'b110, fill(8'd2));
    push(48);
    step(3'b110, fill(8'd2));
    push(-16);
    step(3'b000, '0);
    check("err_clean", VW'(bus.err), '0);

    // Extremes and conflict: key beat arrives as load+execute.
    load_key(8'h80, 3'b011);
    step(3'b000, '0);
    check("err_conflict", VW'(bus.err), VW'(1));
    step(3'b110, fill(8'h80));
    push(131072);
    step(3'b100, fill(8'h7F));
    step(3'b010, fill(8'h80));
    step(3'b110, fill(8'h80));
    push(262144);
    repeat (4) step(3'b000, '0);
    check("err_sticky", VW'(bus.err), VW'(1));

    // Reset mid-chunk: pre-reset beats must never surface.
    step(3'b010, fill(8'd1));
    step(3'b010, fill(8'd1));
    do_reset();
    load_key(8'd2, 3'b001);
    step(3'b110, fill(8'd3));
    push(48);
    repeat (6) step(3'b000, '0);

    check("sb_drained", VW'(sb_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_col_acc.md
Name: mac_col_acc

Overview:
- Next-generation systolic MAC column for the attention/dot-product array, parametrised in column count and accumulator width.
- Holds one stationary key vector per column and forwards query vectors to the next column.
- Computes a PR-lane signed dot product per execute beat and accumulates a multi-beat chunk internally.
- Double-buffers the key, so a new key can be loaded while an accumulation is still running.
- Emits one result plus a FIFO write strobe at the end of each chunk.

Parameters:
- BW, 8, element width (signed two's complement).
- PR, 8, lanes per vector.
- BW_PSUM, 2*BW+4, per-beat dot-product width.
- BW_ACC, 2*BW+8, accumulator and output width.
- NUM_COL, 8, columns in the chain.
- COL_ID, 0, position in the chain (0 = first, fed directly).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- q_in  in  PR*BW  query/key vector; lane i at bits [i*BW +: BW].
- i_inst  in  3  [0] load, [1] execute, [2] last (valid only with execute).
- q_out  out  PR*BW  registered q_in forwarded to the next column.
- o_inst  out  3  registered i_inst forwarded to the next column.
- out  out  BW_ACC  accumulated chunk result (signed).
- fifo_wr  out  1  one-cycle strobe; out is valid in the same cycle.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. All logic is on the rising edge of clk.

Reset:
- q_out, o_inst, out, fifo_wr, err, all pipeline registers, the accumulator, key_active and key_shadow clear to 0.
- Load counter clears to 0; key_pending clears to 0; accumulator idle.

Forwarding stage (edge E1):
- inst_q <= i_inst every cycle.
- query_q <= q_in when i_inst[0] or i_inst[1]; otherwise it holds.
- q_out = query_q, o_inst = inst_q; one cycle of skew per column.

Load / key capture:
- cnt counts registered load beats.
- When i_inst[0]=1 at an edge and cnt == NUM_COL-1-COL_ID: key_shadow <= q_in, key_pending <= 1, and cnt stops advancing for the rest of the burst (exactly one capture per burst).
- cnt returns to 0 at the first edge where inst_q[0]=1 and i_inst[0]=0 (end of burst).
- A burst shorter than NUM_COL-COL_ID beats captures nothing; key_pending is unchanged.
- Result: all columns capture simultaneously, and column c holds burst beat NUM_COL-1-c.

Key promotion:
- Happens at E1 of an execute beat that starts a new chunk (accumulator idle) while key_pending=1.
- Action: key_active <= key_shadow, key_pending <= 0.
- That beat already uses the new key.
- A key loaded mid-chunk never affects the running chunk.

Conflict:
- i_inst[0] and i_inst[1] both set: load wins, execute and last are ignored, err <= 1 (sticky until reset).
- last without execute: ignored, err <= 1.

Datapath:
- E2: psum_q <= sum over i of query_q[i]*key_active[i], signed, full-precision sign-extended to BW_PSUM. Valid and last bits are pipelined alongside.
- E3: acc <= (first beat of chunk ? 0 : acc) + sign-extended psum_q. Wraps modulo 2^BW_ACC with no saturation.
- On a last beat, out <= the new acc value and fifo_wr = 1 for one cycle; the accumulator returns to idle.
- Latency: last-beat presentation at cycle t gives fifo_wr at cycle t+3.
- out holds its value between strobes.
- Back-to-back chunks are allowed with no bubbles.
- A single-beat chunk (execute+last) is legal.

Mid-operation reset:
- In-flight beats are discarded; no fifo_wr is issued.
- key_active and key_pending are lost.

Idle cycles (i_inst=0):
- Allowed inside a chunk; they neither accumulate nor terminate it.

Test Plan:
- Reset check: assert reset 2 cycles with random q_in/i_inst -> out=0, fifo_wr=0, err=0, q_out=0, o_inst=0.
- Key capture: COL_ID=2, NUM_COL=8; load beats whose lanes all equal k for k=0..7; then one execute+last beat with query lanes all 1 -> column holds key 5; out=40 with fifo_wr exactly 3 cycles after the beat; q_out/o_inst lag the inputs by 1 cycle.
- Accumulation: key lanes all 3; 4 execute beats with query lanes 1, 2, 3, 4 (last on beat 4), idle cycle inserted after beat 2 -> single fifo_wr, out=240.
- Double buffering: key A = all 1; start 3-beat chunk with query all 2; mid-chunk load key B = all -1; finish chunk; then new 1-beat chunk with query all 2 -> first out=48, second out=-16.
- Extremes and conflict: key and query lanes all -128 -> out=131072. A cycle with i_inst=3'b011 -> err=1 and key captured as load. A later execute+last still produces a result.
- Reset mid-chunk: 2 of 4 beats issued, then reset, then a fresh 1-beat chunk (after reload) -> no stale fifo_wr; result excludes the pre-reset beats.
